// File: rtl/subpel_window_scheduler.sv
// Block sequencer for the sub-pixel interpolator: loads a WIN x WIN pixel window,
// runs the interpolator for RUN_CYCLES, then hands the block off via valid/ready.
module subpel_window_scheduler #(
  parameter int WIN        = 15,
  parameter int PIX_W      = 8,
  parameter int RUN_CYCLES = 32,
  parameter int BLK_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [WIN*WIN*PIX_W-1:0] win_buffer,
  output logic                     interp_run,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     busy,
  output logic [BLK_W-1:0]         blk_count
);

  localparam int NPIX  = WIN * WIN;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] load_idx;
  logic [IDX_W-1:0] load_idx_nxt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_cnt_nxt;
  logic             load_we;
  logic             blk_inc;

  // Every output is a pure decode of the registered state, so none depends
  // combinationally on an input and all fall to zero the moment rst rises.
  assign pix_ready  = (state == LOAD);
  assign interp_run = (state == RUN);
  assign res_valid  = (state == DONE);
  assign busy       = (state == RUN) || (state == DONE);

  always_comb begin
    state_nxt    = state;
    load_idx_nxt = load_idx;
    run_cnt_nxt  = run_cnt;
    load_we      = 1'b0;
    blk_inc      = 1'b0;

    if (flush) begin
      // Abort wins over everything: a pixel or res_ready in this cycle is dropped.
      state_nxt    = LOAD;
      load_idx_nxt = '0;
      run_cnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = LOAD;
        end
        LOAD: begin
          if (pix_valid) begin
            load_we = 1'b1;
            if (load_idx == LAST_IDX) begin
              load_idx_nxt = '0;
              run_cnt_nxt  = '0;
              state_nxt    = RUN;
            end else begin
              load_idx_nxt = load_idx + 1'b1;
            end
          end
        end
        RUN: begin
          if (run_cnt == LAST_RUN) begin
            run_cnt_nxt = '0;
            state_nxt   = DONE;
          end else begin
            run_cnt_nxt = run_cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            blk_inc   = 1'b1;
            state_nxt = LOAD;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      load_idx  <= '0;
      run_cnt   <= '0;
      blk_count <= '0;
    end else begin
      state    <= state_nxt;
      load_idx <= load_idx_nxt;
      run_cnt  <= run_cnt_nxt;
      if (blk_inc) begin
        blk_count <= blk_count + 1'b1;
      end
    end
  end

  // Window storage is written only while loading, which keeps it frozen for the
  // interpolator through RUN and DONE; row-major, pixel 0 in the low byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_buffer <= '0;
    end else if (load_we) begin
      win_buffer[load_idx*PIX_W +: PIX_W] <= pix_in;
    end
  end

endmodule

// File: doc/subpel_window_scheduler.md
Name: subpel_window_scheduler

Overview:
- Sequences the sub-pixel interpolation datapath, one block per pass.
- Collects a 15x15 integer-pixel window from an 8-bit pixel stream into the 1800-bit window buffer. Holds the buffer stable while the interpolator runs for a fixed number of cycles, then signals block completion to the downstream consumer with a valid/ready handshake.
- Sits between the reference-pixel fetch stream and the interpolator's in_buffer/run control.

Parameters:
WIN, 15, window side length in pixels
PIX_W, 8, bits per pixel
RUN_CYCLES, 32, interpolator run length per block in cycles (>=1)
BLK_W, 16, width of the block counter

Ports:
clk  input  1  clock, all flops rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort of the current block
pix_in  input  PIX_W  incoming integer pixel, raster order
pix_valid  input  1  pix_in valid
pix_ready  output  1  scheduler accepts a pixel this cycle
win_buffer  output  WIN*WIN*PIX_W (1800)  packed window to interpolator in_buffer
interp_run  output  1  interpolator enable; low holds the interpolator in reset
res_valid  output  1  interpolation results for the current window are complete
res_ready  input  1  consumer has taken the results
busy  output  1  high in RUN or DONE
blk_count  output  BLK_W  blocks completed, wraps modulo 2^BLK_W

Behaviour:
- States: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from registered state; there is no input-to-output combinational path.
- Reset (async, immediate) sets:
  - state=IDLE, load_idx=0, run_cnt=0, blk_count=0, win_buffer=0.
  - pix_ready=0, interp_run=0, res_valid=0, busy=0.
- IDLE: moves unconditionally to LOAD on the next edge.
- LOAD:
  - pix_ready=1.
  - On each pix_valid&pix_ready, pix_in is written to win_buffer[8*load_idx +: 8], then load_idx++.
  - Packing is row-major with stride WIN: load_idx = row*15 + col. Pixel 0 lands at [7:0]; pixel 224 lands at [1799:1792].
  - pix_valid low: no write, no index change.
  - Accepting the pixel at load_idx==224: load_idx returns to 0 and the state moves to RUN.
- RUN:
  - interp_run=1, pix_ready=0.
  - run_cnt counts 0..RUN_CYCLES-1, so interp_run is high for exactly RUN_CYCLES consecutive cycles.
  - At run_cnt==RUN_CYCLES-1: run_cnt returns to 0 and the state moves to DONE.
- DONE:
  - res_valid=1 and held until res_ready is sampled high. res_ready may already be high on the first DONE cycle; it is then accepted that cycle.
  - On handshake: blk_count++ and the state moves to LOAD.
  - interp_run=0 in DONE.
- win_buffer changes only in LOAD. It is bit-stable throughout RUN and DONE.
- busy = (state==RUN)|(state==DONE).
- flush:
  - Has priority over all transitions and handshakes in the same cycle.
  - Next state is LOAD with load_idx=0, run_cnt=0, res_valid=0, interp_run=0.
  - A pixel presented with flush is discarded.
  - blk_count and win_buffer contents are retained; stale bytes are overwritten by the next load.
  - A res_ready coinciding with flush does not increment blk_count.
- Async reset mid-operation: all outputs reach reset values without a clock edge. The first edge after rst deasserts enters IDLE→LOAD sequencing afresh.
- blk_count wraps from 2^BLK_W-1 to 0 silently.

Test Plan:
- Stream from reset, 225 back-to-back pixels with value k mod 256 → pix_ready falls the cycle after the 225th accept. win_buffer[7:0]=0x00, [127:120]=0x0F (row1,col0), [1799:1792]=0xE0. interp_run high exactly 32 cycles, then res_valid=1.
- res_ready held low 10 cycles in DONE → res_valid stays 1, pix_ready 0, blk_count 0, win_buffer unchanged. Raising res_ready → blk_count=1 and pix_ready=1 on the following cycle.
- pix_valid asserted every other cycle with values 0xA0+k → exactly 225 accepts are needed; the byte at index n equals the n-th accepted value; idle cycles leave load_idx unchanged.
- flush at load_idx=100, then a fresh 225-pixel load of 0x55 → all 225 bytes read 0x55. flush at run_cnt=10 → interp_run low the next cycle, no res_valid, blk_count unchanged.
- rst asserted mid-RUN between clock edges → interp_run, busy, win_buffer go to 0 immediately. After release: LOAD at the 2nd edge, and a full block completes normally.
- Two blocks back-to-back with res_ready tied high → res_valid is 1 for one cycle per block, blk_count=2, and block-2 data fully replaces block-1 data.
